// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared widths, opcodes and instruction field layout for the 16-bit datapath
package proc_pkg;

    localparam int DATA_W  = 16;
    localparam int NREGS   = 8;
    localparam int IMM_W   = 6;
    localparam int REG_AW  = 3;
    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int RD_HI   = 12;
    localparam int RD_LO   = 10;
    localparam int RS1_HI  = 9;
    localparam int RS1_LO  = 7;
    localparam int IMM_BIT = 6;
    localparam int RS2_HI  = 5;
    localparam int RS2_LO  = 3;
    localparam int IMM_HI  = 5;
    localparam int IMM_LO  = 0;

    // Field order mirrors the bit layout so a plain cast decodes an instruction.
    typedef struct packed {
        logic [2:0]       op;
        logic [2:0]       rd;
        logic [2:0]       rs1;
        logic             imm;
        logic [IMM_W-1:0] low;
    } instr_t;

endpackage

// File: rtl/regfile_8x16.sv
// rtl/regfile_8x16.sv - register file, one write port, two async read ports, r0 hardwired to zero
module regfile_8x16
    import proc_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int NR = NREGS,
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr0,
    output logic [DW-1:0] rdata0,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1
);

    logic [DW-1:0] regs_q [NR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) regs_q[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata0 = (raddr0 == '0) ? '0 : regs_q[raddr0];
    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];

endmodule

// File: rtl/operand_issue.sv
// rtl/operand_issue.sv - decode/operand-fetch stage with EX/WB forwarding and a registered ALU issue slot
module operand_issue
    import proc_pkg::*;
#(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int NREGS  = proc_pkg::NREGS,
    parameter int IMM_W  = proc_pkg::IMM_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [2:0]          alu_sel,
    output logic [REG_AW-1:0]   out_rd,
    input  logic                ex_fwd_en,
    input  logic [REG_AW-1:0]   ex_fwd_rd,
    input  logic [DATA_W-1:0]   ex_fwd_data,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [15:0]         issue_cnt,
    output logic [15:0]         stall_cnt
);

    instr_t              ins;
    logic [REG_AW-1:0]   rs2;
    logic [DATA_W-1:0]   rf_rs1, rf_rs2;
    logic [DATA_W-1:0]   op_a, op_b;
    logic                accept;

    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]          sel_q, sel_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [15:0]         issue_q, issue_d, stall_q, stall_d;

    assign ins = instr_t'(in_instr);
    assign rs2 = ins.low[IMM_W-1 -: REG_AW];

    regfile_8x16 #(
        .DW (DATA_W),
        .NR (NREGS),
        .AW (REG_AW)
    ) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr0 (ins.rs1),
        .rdata0 (rf_rs1),
        .raddr1 (rs2),
        .rdata1 (rf_rs2)
    );

    // EX outranks WB because it carries the younger result for the same register.
    function automatic logic [DATA_W-1:0] fetch(
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_data,
        input logic              w_en,
        input logic [REG_AW-1:0] w_rd,
        input logic [DATA_W-1:0] w_data
    );
        if (addr == '0)                    return '0;
        else if (ex_en && (ex_rd == addr)) return ex_data;
        else if (w_en && (w_rd == addr))   return w_data;
        else                               return rf_val;
    endfunction

    always_comb begin
        op_a = fetch(ins.rs1, rf_rs1, ex_fwd_en, ex_fwd_rd, ex_fwd_data,
                     wb_en, wb_rd, wb_data);
        if (ins.imm) begin
            op_b = {{(DATA_W-IMM_W){1'b0}}, ins.low};
        end else begin
            op_b = fetch(rs2, rf_rs2, ex_fwd_en, ex_fwd_rd, ex_fwd_data,
                         wb_en, wb_rd, wb_data);
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        issue_d = issue_q;
        stall_d = stall_q;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = op_a;
            b_d     = op_b;
            sel_d   = ins.op;
            rd_d    = ins.rd;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (valid_q && out_ready)  issue_d = issue_q + 16'd1;
        if (valid_q && !out_ready) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            rd_q    <= rd_d;
            issue_q <= issue_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid = valid_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;
    assign out_rd    = rd_q;
    assign issue_cnt = issue_q;
    assign stall_cnt = stall_q;

endmodule
